jtbubl_sndcomm: RTL

Mailbox between the main Z80 and the sound Z80. The main CPU writes a command byte that the sound CPU pops. The sound CPU writes a reply byte that the main CPU reads. The block generates the sound CPU's edge-triggered NMI for each pending command. It sits directly downstream of the main CPU decoder's sound-latch strobe and replaces the plain `snd_latch` register.

---
 rtl/jtbubl_sndcomm_if.sv | 40 ++++
 rtl/jtbubl_sndcomm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_sndcomm_if.sv
// Main-CPU / sound-CPU mailbox bus: command, reply, status and NMI signals.
// Purely structural, so no latency of its own.
// No backpressure: every select is a level-sensitive CPU access strobe.
//
// Port summary (named from the mailbox's point of view, i.e. the slave modport):
//   main_wr/main_din   : main CPU command write select and byte
//   main_rd/main_dout  : main CPU reply read select and reply byte
//   main_stat          : {overflow, reply_valid, cmd_pending}
//   snd_rd/snd_dout    : sound CPU command read select and queue head
//   snd_wr/snd_din     : sound CPU reply write select and byte
//   snd_nmien/nmidis   : sound CPU NMI enable/disable write selects
//   snd_nmi_n          : active-low NMI to the sound CPU
interface jtbubl_sndcomm_if;
    logic       main_wr;
    logic [7:0] main_din;
    logic       main_rd;
    logic [7:0] main_dout;
    logic [2:0] main_stat;
    logic       snd_rd;
    logic [7:0] snd_dout;
    logic       snd_wr;
    logic [7:0] snd_din;
    logic       snd_nmien;
    logic       snd_nmidis;
    logic       snd_nmi_n;

    // CPU side: drives selects and data, observes mailbox outputs.
    modport master (
        output main_wr, main_din, main_rd,
        output snd_rd, snd_wr, snd_din, snd_nmien, snd_nmidis,
        input  main_dout, main_stat, snd_dout, snd_nmi_n
    );

    // Mailbox side.
    modport slave (
        input  main_wr, main_din, main_rd,
        input  snd_rd, snd_wr, snd_din, snd_nmien, snd_nmidis,
        output main_dout, main_stat, snd_dout, snd_nmi_n
    );
endinterface

// File: rtl/jtbubl_sndcomm.sv
// Command/reply mailbox between main Z80 and sound Z80, with per-command sound NMI.
// Latency: data/flags visible 1 clk after a select's rising edge; NMI falls 2 clks after a command write at the earliest.
// Backpressure: none; a command written while the queue is full is dropped and flagged as overflow.
//
// Ports: clk24 (system clock), rst_n (async active-low reset), cen (sound CPU
// clock enable, paces the NMI gap only), bus (jtbubl_sndcomm_if.slave).
// Parameters: NMI_GAP = minimum cen ticks of snd_nmi_n high between NMIs,
// FIFOAW = command queue address width (FIFO build only).
// Build option: define JTBUBL_SNDFIFO_EN for a 2^FIFOAW deep command FIFO;
// otherwise the command path is the single 8-bit latch of the original board.
module jtbubl_sndcomm #(
    parameter int NMI_GAP = 4,
    parameter int FIFOAW  = 2
) (
    input  logic            clk24,
    input  logic            rst_n,
    input  logic            cen,
    jtbubl_sndcomm_if.slave bus
);

    // ------------------------------------------------------------------
    // Select edge detection. sel_last resets to all ones so a strobe that
    // is already high when reset releases never counts as an access.
    // ------------------------------------------------------------------
    logic [5:0] sel;
    logic [5:0] sel_last_q, sel_last_d;
    logic [5:0] sel_edge;
    logic       mwr_edge, mrd_edge, srd_edge, swr_edge, nen_edge, ndis_edge;

    always_comb begin
        sel        = {bus.snd_nmidis, bus.snd_nmien, bus.snd_wr,
                      bus.snd_rd, bus.main_rd, bus.main_wr};
        sel_last_d = sel;
        sel_edge   = sel & ~sel_last_q;
    end

    assign mwr_edge  = sel_edge[0];
    assign mrd_edge  = sel_edge[1];
    assign srd_edge  = sel_edge[2];
    assign swr_edge  = sel_edge[3];
    assign nen_edge  = sel_edge[4];
    assign ndis_edge = sel_edge[5];

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    logic [7:0] snd_dout_q, snd_dout_d;
    logic       cmd_pending_q, cmd_pending_d;
    logic       ovf_set;

`ifdef JTBUBL_SNDFIFO_EN
    localparam int DEPTH = 1 << FIFOAW;

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [FIFOAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFOAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFOAW:0]   cnt_q, cnt_d;
    logic              fifo_full, fifo_empty, push, pop;

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == (FIFOAW+1)'(DEPTH));
        pop        = srd_edge & ~fifo_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push       = mwr_edge & (~fifo_full | pop);
        ovf_set    = mwr_edge & fifo_full & ~pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        snd_dout_d = snd_dout_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.main_din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Present the new head; an emptied queue keeps showing the last byte.
        if (cnt_d != '0) begin
            snd_dout_d = mem_d[rd_ptr_d];
        end
        cmd_pending_d = (cnt_d != '0);
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    // Single latch: a new write always replaces the byte. Overflow only
    // flags a lost byte, so a read in the same cycle consumes the old one.
    always_comb begin
        snd_dout_d    = snd_dout_q;
        cmd_pending_d = cmd_pending_q;
        ovf_set       = 1'b0;
        if (mwr_edge) begin
            snd_dout_d    = bus.main_din;
            cmd_pending_d = 1'b1;
            ovf_set       = cmd_pending_q & ~srd_edge;
        end else if (srd_edge) begin
            cmd_pending_d = 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky overflow (read-to-clear by main CPU), reply register, NMI enable
    // ------------------------------------------------------------------
    logic       ovf_q, ovf_d;
    logic [7:0] reply_q, reply_d;
    logic       reply_vld_q, reply_vld_d;
    logic       nmi_en_q, nmi_en_d;

    always_comb begin
        ovf_d = ovf_q;
        if (mrd_edge) begin
            ovf_d = 1'b0;
        end
        // A fresh loss in the same cycle as the status read must not vanish.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        reply_d     = reply_q;
        reply_vld_d = reply_vld_q;
        if (swr_edge) begin
            reply_d     = bus.snd_din;
            reply_vld_d = 1'b1;
        end else if (mrd_edge) begin
            reply_vld_d = 1'b0;
        end

        nmi_en_d = nmi_en_q;
        if (ndis_edge) begin
            nmi_en_d = 1'b0;
        end else if (nen_edge) begin
            nmi_en_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // NMI state machine
    // ------------------------------------------------------------------
    localparam int GW = (NMI_GAP < 1) ? 1 : $clog2(NMI_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(NMI_GAP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } nmi_state_t;

    nmi_state_t    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          nmi_n_q, nmi_n_d;

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (nmi_en_q && cmd_pending_q && (gap_q == '0)) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // The sound CPU reading the command is its acknowledge.
                if (srd_edge || !nmi_en_q) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: gap counter and registered NMI line
    always_comb begin
        gap_d = gap_q;
        if ((state_q == ST_ASSERT) && (state_d == ST_GAP)) begin
            gap_d = GAP_LOAD;
        end else if ((state_q == ST_GAP) && cen && (gap_q != '0)) begin
            gap_d = gap_q - 1'b1;
        end
        // Register the line from the next state so it is glitch-free.
        nmi_n_d = (state_d != ST_ASSERT);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            sel_last_q    <= '1;
            snd_dout_q    <= 8'hFF;
            cmd_pending_q <= 1'b0;
            ovf_q         <= 1'b0;
            reply_q       <= 8'hFF;
            reply_vld_q   <= 1'b0;
            nmi_en_q      <= 1'b0;
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            nmi_n_q       <= 1'b1;
        end else begin
            sel_last_q    <= sel_last_d;
            snd_dout_q    <= snd_dout_d;
            cmd_pending_q <= cmd_pending_d;
            ovf_q         <= ovf_d;
            reply_q       <= reply_d;
            reply_vld_q   <= reply_vld_d;
            nmi_en_q      <= nmi_en_d;
            state_q       <= state_d;
            gap_q         <= gap_d;
            nmi_n_q       <= nmi_n_d;
        end
    end

    assign bus.main_dout = reply_q;
    assign bus.main_stat = {ovf_q, reply_vld_q, cmd_pending_q};
    assign bus.snd_dout  = snd_dout_q;
    assign bus.snd_nmi_n = nmi_n_q;

endmodule
